// File: rtl/dcache_ctrl.sv
// Write-back, write-allocate controller for a 2-way, 16-set data cache with 32-byte lines.
// Hits finish in the lookup cycle; a miss stalls the CPU through writeback, allocate and refill.
module dcache_ctrl (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cpu_req_i,
    input  logic         cpu_write_i,
    input  logic [31:0]  cpu_addr_i,
    input  logic [31:0]  cpu_data_i,
    output logic [31:0]  cpu_data_o,
    output logic         cpu_stall_o,
    output logic         sram_enable_o,
    output logic         sram_write_o,
    output logic [3:0]   sram_addr_o,
    output logic [24:0]  sram_tag_o,
    output logic [255:0] sram_data_o,
    input  logic         sram_hit_i,
    input  logic [24:0]  sram_tag_i,
    input  logic [255:0] sram_data_i,
    output logic         mem_enable_o,
    output logic         mem_write_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i
);

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, REFILL} state_t;

    state_t        state_q, state_d;
    logic [22:0]   tag_q;
    logic [3:0]    index_q;
    logic          write_q;
    logic [31:0]   wdata_q;
    logic [22:0]   victim_tag_q;
    logic [255:0]  victim_data_q;
    logic [255:0]  line_q;
    logic [255:0]  merged_line;

    logic [22:0]   req_tag;
    logic [3:0]    req_index;
    logic [2:0]    req_word;
    logic          miss_start;
    logic          unused_bits;

    assign req_tag    = cpu_addr_i[31:9];
    assign req_index  = cpu_addr_i[8:5];
    assign req_word   = cpu_addr_i[4:2];
    assign miss_start = (state_q == IDLE) && cpu_req_i && !sram_hit_i;

    // Byte offset is always zero for word-aligned accesses. The latched write flag and
    // store data are kept for observability; the re-lookup uses the held CPU port.
    assign unused_bits = ^{cpu_addr_i[1:0], write_q, wdata_q};

    assign cpu_stall_o = cpu_req_i && !((state_q == IDLE) && sram_hit_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            tag_q         <= '0;
            index_q       <= '0;
            write_q       <= 1'b0;
            wdata_q       <= '0;
            victim_tag_q  <= '0;
            victim_data_q <= '0;
            line_q        <= '0;
        end else begin
            state_q <= state_d;
            if (miss_start) begin
                tag_q         <= req_tag;
                index_q       <= req_index;
                write_q       <= cpu_write_i;
                wdata_q       <= cpu_data_i;
                victim_tag_q  <= sram_tag_i[22:0];
                victim_data_q <= sram_data_i;
            end
            if ((state_q == ALLOCATE) && mem_ack_i) begin
                line_q <= mem_data_i;
            end
        end
    end

    always_comb begin
        merged_line = sram_data_i;
        merged_line[32*req_word +: 32] = cpu_data_i;
    end

    always_comb begin
        state_d       = state_q;
        cpu_data_o    = '0;
        sram_enable_o = 1'b0;
        sram_write_o  = 1'b0;
        sram_addr_o   = '0;
        sram_tag_o    = '0;
        sram_data_o   = '0;
        mem_enable_o  = 1'b0;
        mem_write_o   = 1'b0;
        mem_addr_o    = '0;
        mem_data_o    = '0;
        case (state_q)
            IDLE: begin
                sram_enable_o = cpu_req_i;
                if (cpu_req_i) begin
                    sram_addr_o = req_index;
                    sram_tag_o  = {2'b10, req_tag};
                    if (sram_hit_i) begin
                        if (cpu_write_i) begin
                            sram_write_o = 1'b1;
                            sram_tag_o   = {2'b11, req_tag};
                            sram_data_o  = merged_line;
                        end else begin
                            cpu_data_o = sram_data_i[32*req_word +: 32];
                        end
                    end else if (sram_tag_i[24] && sram_tag_i[23]) begin
                        state_d = WRITEBACK;
                    end else begin
                        state_d = ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {victim_tag_q, index_q, 5'b0};
                mem_data_o   = victim_data_q;
                if (mem_ack_i) state_d = ALLOCATE;
            end
            ALLOCATE: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {tag_q, index_q, 5'b0};
                if (mem_ack_i) state_d = REFILL;
            end
            REFILL: begin
                // Tag is absent from the set, so storage places this line in the LRU way.
                sram_enable_o = 1'b1;
                sram_write_o  = 1'b1;
                sram_addr_o   = index_q;
                sram_tag_o    = {2'b10, tag_q};
                sram_data_o   = line_q;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
